// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC reads to instruction memory, waits out slow
// responses, and folds in redirects and HALT before handing words to the IF/ID latch.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [15:0] redirect_pc_in,
    input  logic        halt_in,
    output logic        mem_rd_out,
    output logic [15:0] mem_addr_out,
    input  logic [15:0] mem_data_in,
    input  logic        mem_done_in,
    output logic [15:0] instruction_out,
    output logic [15:0] pc_plus2_out,
    output logic        imem_stall_out,
    output logic        fetch_valid_out,
    output logic        halted_out
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc, pc_next;
    logic        redirect_pending, redirect_pending_next;
    logic [15:0] redirect_target, redirect_target_next;
    logic        halt_pending, halt_pending_next;

    logic        rd_req;
    logic        valid;
    logic        stall;
    logic [15:0] redirect_addr;
    logic [15:0] pc_inc;

    assign redirect_addr = redirect_pc_in & 16'hFFFE;
    assign pc_inc        = pc + 16'd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            redirect_pending <= 1'b0;
            redirect_target  <= 16'h0000;
            halt_pending     <= 1'b0;
        end else begin
            state            <= state_next;
            pc               <= pc_next;
            redirect_pending <= redirect_pending_next;
            redirect_target  <= redirect_target_next;
            halt_pending     <= halt_pending_next;
        end
    end

    // Redirect beats halt beats stall; a redirect or halt in FETCH issues no read.
    always_comb begin
        state_next            = state;
        pc_next               = pc;
        redirect_pending_next = redirect_pending;
        redirect_target_next  = redirect_target;
        halt_pending_next     = halt_pending;
        rd_req                = 1'b0;
        valid                 = 1'b0;
        stall                 = 1'b0;

        case (state)
            FETCH: begin
                if (redirect_in) begin
                    pc_next = redirect_addr;
                end else if (halt_in) begin
                    state_next = HALTED;
                end else if (!stall_in) begin
                    rd_req = 1'b1;
                    if (mem_done_in) begin
                        valid   = 1'b1;
                        pc_next = pc_inc;
                    end else begin
                        stall      = 1'b1;
                        state_next = WAIT;
                    end
                end
            end

            WAIT: begin
                stall = !mem_done_in;
                if (redirect_in) begin
                    redirect_pending_next = 1'b1;
                    redirect_target_next  = redirect_addr;
                    halt_pending_next     = 1'b0;
                end else if (halt_in && !redirect_pending) begin
                    halt_pending_next = 1'b1;
                end

                // The read in flight finishes here; cancelled words are dropped.
                if (mem_done_in) begin
                    redirect_pending_next = 1'b0;
                    redirect_target_next  = 16'h0000;
                    halt_pending_next     = 1'b0;
                    if (redirect_in) begin
                        pc_next    = redirect_addr;
                        state_next = FETCH;
                    end else if (redirect_pending) begin
                        pc_next    = redirect_target;
                        state_next = FETCH;
                    end else if (halt_in || halt_pending) begin
                        state_next = HALTED;
                    end else begin
                        valid      = 1'b1;
                        pc_next    = pc_inc;
                        state_next = FETCH;
                    end
                end
            end

            HALTED: begin
                state_next = HALTED;
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Outputs are gated by rst so the unit stays quiet while reset is held.
    assign mem_rd_out      = rst && rd_req;
    assign fetch_valid_out = rst && valid;
    assign imem_stall_out  = rst && stall;
    assign halted_out      = rst && (state == HALTED);
    assign instruction_out = fetch_valid_out ? mem_data_in : NOP_INSTR;
    assign mem_addr_out    = pc;
    assign pc_plus2_out    = pc_inc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, 16'h0800, instruction emitted whenever no valid fetch is presented.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 SHALL have port stall_in  input  1  hazard stall; hold PC, issue no new request.
REQ-006 SHALL have port redirect_in  input  1  taken branch/jump from a later stage.
REQ-007 SHALL have port redirect_pc_in  input  16  redirect target; bit 0 ignored, treated as 0.
REQ-008 SHALL have port halt_in  input  1  HALT decoded; stop fetching.
REQ-009 SHALL have port mem_rd_out  output  1  read request to instruction memory.
REQ-010 SHALL have port mem_addr_out  output  16  request address, equal to current PC.
REQ-011 SHALL have port mem_data_in  input  16  instruction word, valid only with mem_done_in.
REQ-012 SHALL have port mem_done_in  input  1  memory completes the outstanding read this cycle.
REQ-013 SHALL have port instruction_out  output  16  instruction toward the IF/ID latch.
REQ-014 SHALL have port pc_plus2_out  output  16  fetched PC + 2 toward the IF/ID latch.
REQ-015 SHALL have port imem_stall_out  output  1  fetch not yet complete; IF/ID latch inserts NOP.
REQ-016 SHALL have port fetch_valid_out  output  1  instruction_out is a real, uncancelled fetch.
REQ-017 SHALL have port halted_out  output  1  unit is in HALTED state.

Function
REQ-018 SHALL implement states FETCH, WAIT, HALTED; encoding is free.
REQ-019 In FETCH with stall_in=0, SHALL drive mem_rd_out=1 and mem_addr_out=PC.
REQ-020 In FETCH with stall_in=1, SHALL drive mem_rd_out=0, keep PC, and stay in FETCH.
REQ-021 In FETCH with mem_rd_out=1 and mem_done_in=1, SHALL present mem_data_in on instruction_out in the same cycle, assert fetch_valid_out, and load PC <= PC+2.
REQ-022 In FETCH with mem_rd_out=1 and mem_done_in=0, SHALL go to WAIT and assert imem_stall_out.
REQ-023 In WAIT, SHALL hold mem_rd_out=0 and mem_addr_out=PC and assert imem_stall_out until mem_done_in=1.
REQ-024 On mem_done_in in WAIT with no pending redirect, SHALL behave as REQ-021, then return to FETCH.
REQ-025 redirect_in in FETCH SHALL load PC <= redirect_pc_in next edge, suppress fetch_valid_out that cycle, and drive instruction_out=NOP_INSTR.
REQ-026 redirect_in in WAIT SHALL record target and pending flag; on mem_done_in, SHALL discard data (NOP_INSTR, fetch_valid_out=0), load PC <= target, clear flag, and go to FETCH.
REQ-027 A second redirect while pending SHALL overwrite the recorded target.
REQ-028 Priority SHALL be redirect_in > halt_in > stall_in; redirect cancels a same-cycle halt.
REQ-029 halt_in (without redirect) in FETCH SHALL go to HALTED; in WAIT, SHALL go to HALTED on mem_done_in with the data discarded.
REQ-030 In HALTED, SHALL drive mem_rd_out=0, instruction_out=NOP_INSTR, fetch_valid_out=0, imem_stall_out=0, halted_out=1, and leave only via reset.
REQ-031 Whenever fetch_valid_out=0, instruction_out SHALL equal NOP_INSTR.
REQ-032 imem_stall_out SHALL be 1 exactly when state is FETCH/WAIT, a request is outstanding, and mem_done_in=0.
REQ-033 pc_plus2_out SHALL equal PC+2 modulo 2^16; 16'hFFFE wraps to 16'h0000.

Reset
REQ-034 rst=0 SHALL immediately force state FETCH, PC=RESET_PC, pending flag and target cleared, regardless of clock or current state, including mid-WAIT.
REQ-035 While rst=0, outputs SHALL be: mem_rd_out=0, instruction_out=NOP_INSTR, fetch_valid_out=0, imem_stall_out=0, halted_out=0, mem_addr_out=RESET_PC, pc_plus2_out=RESET_PC+2.
REQ-036 First request SHALL issue in the first cycle after rst deasserts.

Verification
REQ-037 Single-cycle memory, 3 fetches from reset -> addresses 0000, 0002, 0004 on consecutive cycles, fetch_valid_out=1 each.
REQ-038 mem_done_in delayed 3 cycles at PC=0010 -> imem_stall_out=1 for 3 cycles, then data presented, PC=0012.
REQ-039 redirect_in to 0041 during WAIT at PC=0020 -> returned word discarded as 0800, next request at 0040.
REQ-040 redirect_in and halt_in same cycle -> PC=redirect target, halted_out stays 0.
REQ-041 halt_in at PC=0030 -> halted_out=1, mem_rd_out=0 for 10 following cycles, stall_in/redirect ignored.
REQ-042 rst pulsed low mid-WAIT and mid-HALTED -> asynchronous return to PC=0000, FETCH, pending cleared.
